// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants and helpers for the decode-side hazard scoreboard.
package hazard_scoreboard_pkg;

  // EX operand mux selects.
  localparam logic [1:0] FWD_REG = 2'b00;  // register file (write-through covers WB)
  localparam logic [1:0] FWD_MEM = 2'b01;  // result of the instruction now in MEM
  localparam logic [1:0] FWD_WB  = 2'b10;  // result of the instruction now in WB

  // Forward select for one operand. The nearer producer (EX) wins over MEM
  // because it holds the younger value of the register.
  function automatic logic [1:0] fwd_pick(input logic hit_ex, input logic hit_mem);
    logic [1:0] sel;
    sel = FWD_REG;
    if (hit_ex) begin
      sel = FWD_MEM;
    end else if (hit_mem) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_slot.sv
// One shadow pipeline slot: {valid, rd, we, is_load} of an in-flight instruction.
// hold keeps the contents, clear loads an empty slot, otherwise d is captured.
module hazard_scoreboard_slot #(
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              clear,
  input  logic              d_valid,
  input  logic [REG_AW-1:0] d_rd,
  input  logic              d_we,
  input  logic              d_is_load,
  output logic              q_valid,
  output logic [REG_AW-1:0] q_rd,
  output logic              q_we,
  output logic              q_is_load
);

  // Slot register; hold has priority over clear so a frozen pipe keeps everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_valid   <= 1'b0;
      q_rd      <= '0;
      q_we      <= 1'b0;
      q_is_load <= 1'b0;
    end else if (!hold) begin
      if (clear) begin
        q_valid   <= 1'b0;
        q_rd      <= '0;
        q_we      <= 1'b0;
        q_is_load <= 1'b0;
      end else begin
        q_valid   <= d_valid;
        q_rd      <= d_rd;
        q_we      <= d_we;
        q_is_load <= d_is_load;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-side hazard scoreboard: tracks EX/MEM/WB destinations, raises
// load-use stall/bubble, load-latency freeze and flush bubble, and registers
// the ALU operand forward selects for the instruction entering EX.
//
// Handshake: ID presents an instruction with id_valid_i; it is consumed on a
// rising edge where dhnf_stall_o is 0. While dhnf_stall_o is 1 ID must hold
// the same instruction stable. A flush bubble consumes (discards) it.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_reg1_RE_i,
  input  logic              id_reg2_RE_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_reg_we_i,
  input  logic              id_is_load_i,
  input  logic              ex_flush_i,
  input  logic              mem_rvalid_i,
  output logic              dhnf_stall_o,
  output logic              dhnf_bubble_o,
  output logic              dhnf_freeze_o,
  output logic [1:0]        dhnf_fwd_a_o,
  output logic [1:0]        dhnf_fwd_b_o,
  output logic [CNT_W-1:0]  dhnf_stall_cnt_o
);

  logic              ex_valid, ex_we, ex_is_load;
  logic [REG_AW-1:0] ex_rd;
  logic              mem_valid, mem_we, mem_is_load;
  logic [REG_AW-1:0] mem_rd;
  logic              wb_valid, wb_we, wb_is_load;
  logic [REG_AW-1:0] wb_rd;

  logic hit_ex_a, hit_ex_b, hit_mem_a, hit_mem_b;
  logic freeze, load_use, stall, bubble, issue;

  // A slot produces rs only if it is a real writer of a non-zero register
  // and the reader actually reads that operand.
  function automatic logic rd_hit(input logic re, input logic v, input logic we,
                                  input logic [REG_AW-1:0] rd,
                                  input logic [REG_AW-1:0] rs);
    return re & v & we & (rd == rs) & (rs != '0);
  endfunction

  // Operand/slot dependency matches.
  always_comb begin
    hit_ex_a  = rd_hit(id_reg1_RE_i, ex_valid,  ex_we,  ex_rd,  id_rs1_i);
    hit_ex_b  = rd_hit(id_reg2_RE_i, ex_valid,  ex_we,  ex_rd,  id_rs2_i);
    hit_mem_a = rd_hit(id_reg1_RE_i, mem_valid, mem_we, mem_rd, id_rs1_i);
    hit_mem_b = rd_hit(id_reg2_RE_i, mem_valid, mem_we, mem_rd, id_rs2_i);
  end

  // Hazard decisions. Freeze dominates everything (flush is deferred until the
  // load data arrives), then flush, then load-use.
  always_comb begin
    freeze   = mem_valid & mem_is_load & ~mem_rvalid_i;
    load_use = ~freeze & ~ex_flush_i & id_valid_i & ex_is_load & (hit_ex_a | hit_ex_b);
    stall    = freeze | load_use;
    bubble   = (~freeze & ex_flush_i) | load_use;
    issue    = id_valid_i & ~bubble;
  end

  // Outputs are forced low while reset is asserted, whatever the inputs do.
  always_comb begin
    dhnf_freeze_o = rst_n & freeze;
    dhnf_stall_o  = rst_n & stall;
    dhnf_bubble_o = rst_n & bubble;
  end

  hazard_scoreboard_slot #(.REG_AW(REG_AW)) u_slot_ex (
    .clk(clk), .rst_n(rst_n), .hold(freeze), .clear(~issue),
    .d_valid(id_valid_i), .d_rd(id_rd_i), .d_we(id_reg_we_i), .d_is_load(id_is_load_i),
    .q_valid(ex_valid), .q_rd(ex_rd), .q_we(ex_we), .q_is_load(ex_is_load)
  );

  hazard_scoreboard_slot #(.REG_AW(REG_AW)) u_slot_mem (
    .clk(clk), .rst_n(rst_n), .hold(freeze), .clear(1'b0),
    .d_valid(ex_valid), .d_rd(ex_rd), .d_we(ex_we), .d_is_load(ex_is_load),
    .q_valid(mem_valid), .q_rd(mem_rd), .q_we(mem_we), .q_is_load(mem_is_load)
  );

  hazard_scoreboard_slot #(.REG_AW(REG_AW)) u_slot_wb (
    .clk(clk), .rst_n(rst_n), .hold(freeze), .clear(1'b0),
    .d_valid(mem_valid), .d_rd(mem_rd), .d_we(mem_we), .d_is_load(mem_is_load),
    .q_valid(wb_valid), .q_rd(wb_rd), .q_we(wb_we), .q_is_load(wb_is_load)
  );

  // The WB slot is tracked for visibility only; the write-through register
  // file means no forward path reads it.
  logic wb_unused;
  assign wb_unused = ^{wb_valid, wb_rd, wb_we, wb_is_load};

  // Forward selects for the instruction entering EX; empty issue gets FWD_REG.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dhnf_fwd_a_o <= FWD_REG;
      dhnf_fwd_b_o <= FWD_REG;
    end else if (!freeze) begin
      if (issue) begin
        dhnf_fwd_a_o <= fwd_pick(hit_ex_a, hit_mem_a);
        dhnf_fwd_b_o <= fwd_pick(hit_ex_b, hit_mem_b);
      end else begin
        dhnf_fwd_a_o <= FWD_REG;
        dhnf_fwd_b_o <= FWD_REG;
      end
    end
  end

  // Saturating count of cycles the front end was held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dhnf_stall_cnt_o <= '0;
    end else if (stall && (dhnf_stall_cnt_o != {CNT_W{1'b1}})) begin
      dhnf_stall_cnt_o <= dhnf_stall_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed pipeline scenarios plus random traffic,
// all checked every cycle against a queue-based model of the in-flight window.
module tb_hazard_scoreboard;

  localparam int REG_AW = 5;
  localparam int CNT_W  = 16;
  localparam int W      = 8;   // model record {valid, rd[4:0], we, is_load}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic              id_valid_i, id_reg1_RE_i, id_reg2_RE_i, id_reg_we_i, id_is_load_i;
  logic [REG_AW-1:0] id_rs1_i, id_rs2_i, id_rd_i;
  logic              ex_flush_i, mem_rvalid_i;
  logic              dhnf_stall_o, dhnf_bubble_o, dhnf_freeze_o;
  logic [1:0]        dhnf_fwd_a_o, dhnf_fwd_b_o;
  logic [CNT_W-1:0]  dhnf_stall_cnt_o;

  hazard_scoreboard #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_reg1_RE_i(id_reg1_RE_i), .id_reg2_RE_i(id_reg2_RE_i),
    .id_rd_i(id_rd_i), .id_reg_we_i(id_reg_we_i), .id_is_load_i(id_is_load_i),
    .ex_flush_i(ex_flush_i), .mem_rvalid_i(mem_rvalid_i),
    .dhnf_stall_o(dhnf_stall_o), .dhnf_bubble_o(dhnf_bubble_o),
    .dhnf_freeze_o(dhnf_freeze_o), .dhnf_fwd_a_o(dhnf_fwd_a_o),
    .dhnf_fwd_b_o(dhnf_fwd_b_o), .dhnf_stall_cnt_o(dhnf_stall_cnt_o)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0]     exp_q[$];   // in-flight instructions, [0]=EX [1]=MEM [2]=WB
  logic [1:0]       exp_fwd_a, exp_fwd_b;
  logic [CNT_W-1:0] exp_cnt;
  logic [CNT_W-1:0] c0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Does in-flight record r supply register rs to a reader with enable re?
  function automatic logic writes(input logic [W-1:0] r, input logic [4:0] rs, input logic re);
    return re && r[7] && r[1] && (r[6:2] == rs) && (rs != 5'd0);
  endfunction

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back('0);
    exp_fwd_a = 2'b00;
    exp_fwd_b = 2'b00;
    exp_cnt   = '0;
  endtask

  // One clock: check every output against the model at the falling edge,
  // advance the model, then return just after the rising edge.
  task automatic tick();
    logic [W-1:0] ex, mem;
    logic frz, lu, stl, bub, iss;
    @(negedge clk);
    ex  = exp_q[0];
    mem = exp_q[1];
    frz = mem[7] && mem[0] && !mem_rvalid_i;
    lu  = !frz && !ex_flush_i && id_valid_i && ex[0] &&
          (writes(ex, id_rs1_i, id_reg1_RE_i) || writes(ex, id_rs2_i, id_reg2_RE_i));
    stl = frz || lu;
    bub = !frz && (ex_flush_i || lu);
    check("freeze", dhnf_freeze_o, frz);
    check("stall",  dhnf_stall_o,  stl);
    check("bubble", dhnf_bubble_o, bub);
    check("fwd_a",  dhnf_fwd_a_o,  exp_fwd_a);
    check("fwd_b",  dhnf_fwd_b_o,  exp_fwd_b);
    check("cnt",    dhnf_stall_cnt_o, exp_cnt);
    if (stl && exp_cnt != {CNT_W{1'b1}}) exp_cnt = exp_cnt + 1'b1;
    if (!frz) begin
      iss = id_valid_i && !bub;
      exp_fwd_a = !iss ? 2'b00 : writes(ex, id_rs1_i, id_reg1_RE_i) ? 2'b01 :
                  writes(mem, id_rs1_i, id_reg1_RE_i) ? 2'b10 : 2'b00;
      exp_fwd_b = !iss ? 2'b00 : writes(ex, id_rs2_i, id_reg2_RE_i) ? 2'b01 :
                  writes(mem, id_rs2_i, id_reg2_RE_i) ? 2'b10 : 2'b00;
      exp_q.push_front(iss ? {1'b1, id_rd_i, id_reg_we_i, id_is_load_i} : 8'h00);
      void'(exp_q.pop_back());
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_id(input logic v, input logic [4:0] rs1, input logic re1,
                        input logic [4:0] rs2, input logic re2,
                        input logic [4:0] rd, input logic we, input logic ld);
    id_valid_i = v;   id_rs1_i = rs1; id_reg1_RE_i = re1;
    id_rs2_i = rs2;   id_reg2_RE_i = re2;
    id_rd_i = rd;     id_reg_we_i = we; id_is_load_i = ld;
  endtask

  task automatic set_nop();
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    set_nop();
    ex_flush_i   = 1'b0;
    mem_rvalid_i = 1'b1;
    repeat (4) tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stall"},  dhnf_stall_o,  1'b0);
    check({tag, "_bubble"}, dhnf_bubble_o, 1'b0);
    check({tag, "_freeze"}, dhnf_freeze_o, 1'b0);
    check({tag, "_fwd_a"},  dhnf_fwd_a_o,  2'b00);
    check({tag, "_fwd_b"},  dhnf_fwd_b_o,  2'b00);
    check({tag, "_cnt"},    dhnf_stall_cnt_o, 16'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    set_nop();
    ex_flush_i   = 1'b1;   // outputs must stay low under reset regardless
    mem_rvalid_i = 1'b0;
    model_reset();
    #12;
    check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    drain();

    // back-to-back ALU dependency: add x5 ; add x6,x5,x5
    set_id(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0); tick();
    set_id(1, 5'd5, 1, 5'd5, 1, 5'd6, 1, 0); tick();
    check("b2b_fwd_a", dhnf_fwd_a_o, 2'b01);
    check("b2b_fwd_b", dhnf_fwd_b_o, 2'b01);

    // distance 2: add x5 ; nop ; sub x7,x5,x1
    drain();
    set_id(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0); tick();
    set_nop(); tick();
    set_id(1, 5'd5, 1, 5'd1, 1, 5'd7, 1, 0); tick();
    check("d2_fwd_a", dhnf_fwd_a_o, 2'b10);
    check("d2_fwd_b", dhnf_fwd_b_o, 2'b00);

    // distance 3: no forward
    drain();
    set_id(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0); tick();
    set_nop(); tick(); tick();
    set_id(1, 5'd5, 1, 5'd1, 1, 5'd7, 1, 0); tick();
    check("d3_fwd_a", dhnf_fwd_a_o, 2'b00);

    // load-use with data on time
    drain();
    c0 = exp_cnt;
    set_id(1, 5'd1, 1, 5'd0, 0, 5'd8, 1, 1); tick();
    set_id(1, 5'd8, 1, 5'd0, 1, 5'd9, 1, 0);
    #1;
    check("lu_stall",  dhnf_stall_o,  1'b1);
    check("lu_bubble", dhnf_bubble_o, 1'b1);
    tick();
    #1;
    check("lu_release", dhnf_stall_o, 1'b0);
    tick();
    check("lu_fwd_a", dhnf_fwd_a_o, 2'b10);
    check("lu_cnt",   dhnf_stall_cnt_o, c0 + 16'd1);

    // slow load: three frozen cycles
    drain();
    set_id(1, 5'd1, 1, 5'd0, 0, 5'd8, 1, 1); tick();
    set_nop(); tick();
    c0 = exp_cnt;
    mem_rvalid_i = 1'b0;
    repeat (3) begin
      #1;
      check("slow_freeze", dhnf_freeze_o, 1'b1);
      tick();
    end
    mem_rvalid_i = 1'b1;
    tick();
    check("slow_cnt", dhnf_stall_cnt_o, c0 + 16'd3);

    // flush beats load-use
    drain();
    set_id(1, 5'd1, 1, 5'd0, 0, 5'd8, 1, 1); tick();
    set_id(1, 5'd8, 1, 5'd8, 1, 5'd9, 1, 0);
    ex_flush_i = 1'b1;
    #1;
    check("fl_lu_bubble", dhnf_bubble_o, 1'b1);
    check("fl_lu_stall",  dhnf_stall_o,  1'b0);
    tick();
    ex_flush_i = 1'b0;

    // flush during freeze waits for the load data
    drain();
    set_id(1, 5'd1, 1, 5'd0, 0, 5'd8, 1, 1); tick();
    set_id(1, 5'd3, 1, 5'd4, 1, 5'd2, 1, 0); tick();
    mem_rvalid_i = 1'b0;
    ex_flush_i   = 1'b1;
    #1;
    check("fl_frz_bubble", dhnf_bubble_o, 1'b0);
    check("fl_frz_stall",  dhnf_stall_o,  1'b1);
    tick(); tick();
    mem_rvalid_i = 1'b1;
    #1;
    check("fl_rel_bubble", dhnf_bubble_o, 1'b1);
    check("fl_rel_stall",  dhnf_stall_o,  1'b0);
    tick();
    ex_flush_i = 1'b0;

    // x0 and read-enable masking
    drain();
    set_id(1, 5'd1, 1, 5'd2, 1, 5'd0, 1, 0); tick();
    set_id(1, 5'd0, 1, 5'd0, 1, 5'd3, 0, 0); tick();
    check("x0_fwd_a", dhnf_fwd_a_o, 2'b00);
    set_id(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0); tick();
    set_id(1, 5'd1, 1, 5'd5, 0, 5'd6, 1, 0); tick();
    check("re_fwd_b", dhnf_fwd_b_o, 2'b00);
    set_id(1, 5'd1, 1, 5'd0, 0, 5'd8, 1, 1); tick();
    set_id(1, 5'd2, 1, 5'd8, 0, 5'd9, 1, 0);
    #1;
    check("re_no_stall", dhnf_stall_o, 1'b0);
    tick();

    // random traffic over a small register range to provoke hazards
    drain();
    for (int i = 0; i < 2500; i++) begin
      set_id($urandom_range(0, 3) != 0,
             5'($urandom_range(0, 4)), $urandom_range(0, 4) != 0,
             5'($urandom_range(0, 4)), $urandom_range(0, 4) != 0,
             5'($urandom_range(0, 4)), $urandom_range(0, 4) != 0,
             $urandom_range(0, 9) < 3);
      ex_flush_i   = $urandom_range(0, 11) == 0;
      mem_rvalid_i = $urandom_range(0, 9) < 6;
      tick();
    end

    // reset in the middle of a freeze
    drain();
    set_id(1, 5'd1, 1, 5'd0, 0, 5'd8, 1, 1); tick();
    set_nop(); tick();
    mem_rvalid_i = 1'b0;
    tick();
    ex_flush_i = 1'b1;
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_frz");
    model_reset();
    @(posedge clk); #1;
    ex_flush_i   = 1'b0;
    mem_rvalid_i = 1'b1;
    rst_n = 1'b1;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Consumer end of the decode-side register-read interface. Takes per-instruction read enables, source/destination indices and write-enable from ID.
- Keeps a shadow copy of in-flight EX/MEM/WB destinations.
- Generates load-use stall/bubble, variable-latency load freeze, branch-flush bubble and registered forwarding selects for the ALU operand muxes.
- Sits beside the ID/EX pipeline register; all pipeline registers obey its stall/freeze outputs.

Parameters:
- REG_AW, 5, register index width.
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- id_valid_i  in  1  ID holds a real instruction
- id_rs1_i  in  REG_AW  source 1 index
- id_rs2_i  in  REG_AW  source 2 index
- id_reg1_RE_i  in  1  rs1 is read (decode read enable)
- id_reg2_RE_i  in  1  rs2 is read
- id_rd_i  in  REG_AW  destination index
- id_reg_we_i  in  1  instruction writes rd
- id_is_load_i  in  1  instruction is a load
- ex_flush_i  in  1  taken branch/jump resolved in EX
- mem_rvalid_i  in  1  load data returned this cycle
- dhnf_stall_o  out  1  hold PC and IF/ID
- dhnf_bubble_o  out  1  load ID/EX with NOP
- dhnf_freeze_o  out  1  hold every pipeline register
- dhnf_fwd_a_o  out  2  EX operand A select
- dhnf_fwd_b_o  out  2  EX operand B select
- dhnf_stall_cnt_o  out  CNT_W  stall+freeze cycle count

Behaviour:
- Async reset: EX/MEM/WB slots invalid, fwd selects FWD_REG, stall_cnt 0. All combinational outputs evaluate to 0 under reset.
- Slot contents: {valid, rd, we, is_load}. A slot with rd==0 or we==0 never matches.
- match_X(rs, RE) = RE & slot_X.valid & slot_X.we & (slot_X.rd==rs) & (rs!=0).
- freeze (combinational) = slot_MEM.valid & slot_MEM.is_load & ~mem_rvalid_i.
  - During freeze: dhnf_freeze_o=1, dhnf_stall_o=1, dhnf_bubble_o=0.
  - All slots, fwd registers and the flush response are held.
  - ex_flush_i is ignored; EX keeps asserting it until unfrozen.
- If not frozen and ex_flush_i=1: dhnf_bubble_o=1, dhnf_stall_o=0. The ID instruction is discarded (EX slot loads invalid). Flush beats load-use.
- If not frozen, no flush, id_valid_i=1, slot_EX.is_load and (match_EX(rs1) | match_EX(rs2)): load-use.
  - dhnf_stall_o=1, dhnf_bubble_o=1 for exactly one cycle.
  - Next cycle the load is in MEM, and the forward select resolves the dependency (FWD_WB after freeze releases).
- Advance (when not frozen): WB←MEM, MEM←EX, EX←ID. The ID contribution is invalid on bubble or when ~id_valid_i.
- Forward selects are registered at advance and used during the issued instruction's EX cycle:
  - match_EX → FWD_MEM (producer will be in MEM).
  - Else match_MEM → FWD_WB.
  - Else FWD_REG; the register file is write-through, so a WB-stage producer needs no forward.
  - EX match has priority over MEM match.
  - A load in EX never yields FWD_MEM; the stall covers it.
- Bubble or invalid issue sets both selects to FWD_REG.
- stall_cnt increments each cycle dhnf_stall_o=1 and saturates at all-ones.
- Load in MEM with mem_rvalid_i already high on entry: no freeze cycle.

Decomposition:
- define.v gets FWD_REG=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10.
- Optional sub-module hazard_slot: one valid/rd/we/is_load register with hold and clear inputs, instantiated three times.

Test Plan:
- Back-to-back ALU dependency: add x5 then add x6,x5,x5 → no stall; second instruction's EX cycle fwd_a=fwd_b=01.
- Distance-2 dependency: add x5, nop, sub x7,x5,x1 → fwd_a=10, fwd_b=00. Distance 3 → both 00.
- Load-use: lw x8 then add x9,x8,x0 with mem_rvalid_i high on the load's MEM cycle → exactly one cycle stall=1, bubble=1; add then sees fwd_a=10; stall_cnt=1.
- Slow load: lw x8 in MEM with mem_rvalid_i low 3 cycles → freeze=1 and stall=1 for 3 cycles, slots unchanged, then advance; stall_cnt=3.
- Flush vs load-use in the same cycle → bubble=1, stall=0. Flush during freeze → ignored until mem_rvalid_i.
- x0 and read-enable masking: writer rd=0, or reader with reg2_RE=0 and a matching rs2 → selects 00, no stall.
- Reset mid-freeze → all outputs 0, counter 0.
